// File: rtl/cu_pkg.sv
// Shared types and instruction-field layout for the multi-cycle control unit.
// Layout, MSB first: {type[2], rd, rs1, rs2, offset[DATA_WIDTH], opcode[4]}.
package cu_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      EXECUTE,
      MEM_ACCESS,
      WRITE_BACK
   } state_t;

   localparam logic [1:0] TYPE_NOP   = 2'b00;
   localparam logic [1:0] TYPE_STD   = 2'b01;
   localparam logic [1:0] TYPE_LOAD  = 2'b10;
   localparam logic [1:0] TYPE_STORE = 2'b11;

   localparam int         OPCODE_W   = 4;
   localparam logic [3:0] OPCODE_RST = 4'b1111;

   // n_idx = number of register-index fields sitting below the field of interest
   function automatic int field_lsb(input int dw, input int ridx, input int n_idx);
      return OPCODE_W + dw + n_idx * ridx;
   endfunction

   function automatic int instr_width(input int dw, input int ridx);
      return 2 + 3 * ridx + dw + OPCODE_W;
   endfunction

endpackage

// File: rtl/cu_regfile.sv
// Register file: two combinational read ports, one synchronous write port, R[i]=i on reset.
// Build option CU_ZERO_REG_EN: R[0] reads as zero and writes to it are dropped.
module cu_regfile #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REGS   = 4,
   parameter int RIDX       = $clog2(NUM_REGS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [RIDX-1:0]       raddr_a_i,
   output logic [DATA_WIDTH-1:0] rdata_a_o,
   input  logic [RIDX-1:0]       raddr_b_i,
   output logic [DATA_WIDTH-1:0] rdata_b_o,
   input  logic                  we_i,
   input  logic [RIDX-1:0]       waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i
);

`ifdef CU_ZERO_REG_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

   always_comb begin
      regs_d = regs_q;
      if (we_i && (!ZERO_EN || waddr_i != '0)) begin
         regs_d[waddr_i] = wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= DATA_WIDTH'(i);
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   assign rdata_a_o = (ZERO_EN && raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
   assign rdata_b_o = (ZERO_EN && raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule

// File: rtl/cu_multicycle.sv
// Multi-cycle control unit: one instruction at a time through DECODE/EXECUTE/MEM_ACCESS/WRITE_BACK.
// Build option CU_ZERO_REG_EN (applied in cu_regfile) hard-wires R[0] to zero.
module cu_multicycle
   import cu_pkg::*;
#(
   parameter  int DATA_WIDTH  = 8,
   parameter  int NUM_REGS    = 4,
   localparam int RIDX        = $clog2(NUM_REGS),
   localparam int INSTR_WIDTH = instr_width(DATA_WIDTH, RIDX)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   instr_valid,
   output logic                   instr_ready,
   input  logic [INSTR_WIDTH-1:0] instr,
   input  logic [DATA_WIDTH-1:0]  result2,
   output logic [DATA_WIDTH-1:0]  operand1,
   output logic [DATA_WIDTH-1:0]  operand2,
   output logic [DATA_WIDTH-1:0]  offset,
   output logic [3:0]             opcode,
   output logic                   sel1,
   output logic                   sel3,
   output logic                   w_r,
   output logic                   retire
);

   localparam int TYPE_LSB = field_lsb(DATA_WIDTH, RIDX, 3);
   localparam int RD_LSB   = field_lsb(DATA_WIDTH, RIDX, 2);
   localparam int RS1_LSB  = field_lsb(DATA_WIDTH, RIDX, 1);
   localparam int RS2_LSB  = field_lsb(DATA_WIDTH, RIDX, 0);

   logic [1:0]            f_type;
   logic [RIDX-1:0]       f_rd, f_rs1, f_rs2;
   logic [DATA_WIDTH-1:0] f_off;
   logic [3:0]            f_opc;

   assign f_type = instr[TYPE_LSB +: 2];
   assign f_rd   = instr[RD_LSB +: RIDX];
   assign f_rs1  = instr[RS1_LSB +: RIDX];
   assign f_rs2  = instr[RS2_LSB +: RIDX];
   assign f_off  = instr[OPCODE_W +: DATA_WIDTH];
   assign f_opc  = instr[0 +: OPCODE_W];

   state_t                state_q, state_d;
   logic [1:0]            type_q, type_d;
   logic [RIDX-1:0]       rd_q, rd_d;
   logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, off_q, off_d;
   logic [3:0]            opc_q, opc_d;
   logic                  sel1_q, sel1_d, sel3_q, sel3_d, w_r_q, w_r_d, retire_q, retire_d;

   logic                  accept;
   logic [DATA_WIDTH-1:0] rdata_a, rdata_b;

   assign instr_ready = (state_q == IDLE);
   assign accept      = instr_valid && instr_ready;

   // Memory-type instructions read R[rd] as the second operand (store data / base).
   cu_regfile #(
      .DATA_WIDTH(DATA_WIDTH),
      .NUM_REGS  (NUM_REGS),
      .RIDX      (RIDX)
   ) u_regfile (
      .clk_i    (clk),
      .rst_i    (rst),
      .raddr_a_i(f_rs1),
      .rdata_a_o(rdata_a),
      .raddr_b_i((f_type == TYPE_STD) ? f_rs2 : f_rd),
      .rdata_b_o(rdata_b),
      .we_i     (state_q == WRITE_BACK),
      .waddr_i  (rd_q),
      .wdata_i  (result2)
   );

   always_comb begin
      state_d  = state_q;
      type_d   = type_q;
      rd_d     = rd_q;
      op1_d    = op1_q;
      op2_d    = op2_q;
      off_d    = off_q;
      opc_d    = opc_q;
      sel1_d   = sel1_q;
      sel3_d   = sel3_q;
      w_r_d    = 1'b0;
      retire_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = DECODE;
               type_d   = f_type;
               rd_d     = f_rd;
               op1_d    = rdata_a;
               op2_d    = rdata_b;
               off_d    = f_off;
               opc_d    = f_opc;
               retire_d = (f_type == TYPE_NOP);
               if (f_type == TYPE_STD) begin
                  sel1_d = 1'b1;
                  sel3_d = 1'b0;
               end else if (f_type != TYPE_NOP) begin
                  sel1_d = 1'b0;
                  sel3_d = 1'b1;
               end
            end
         end
         DECODE:     state_d = (type_q == TYPE_NOP) ? IDLE : EXECUTE;
         EXECUTE: begin
            if (type_q == TYPE_STD) begin
               state_d  = WRITE_BACK;
               retire_d = 1'b1;
            end else begin
               state_d  = MEM_ACCESS;
               w_r_d    = (type_q == TYPE_STORE);
               retire_d = (type_q == TYPE_STORE);
            end
         end
         MEM_ACCESS: begin
            state_d  = (type_q == TYPE_LOAD) ? WRITE_BACK : IDLE;
            retire_d = (type_q == TYPE_LOAD);
         end
         WRITE_BACK: state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         type_q   <= TYPE_NOP;
         rd_q     <= '0;
         op1_q    <= '0;
         op2_q    <= '0;
         off_q    <= '0;
         opc_q    <= OPCODE_RST;
         sel1_q   <= 1'b0;
         sel3_q   <= 1'b0;
         w_r_q    <= 1'b0;
         retire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         type_q   <= type_d;
         rd_q     <= rd_d;
         op1_q    <= op1_d;
         op2_q    <= op2_d;
         off_q    <= off_d;
         opc_q    <= opc_d;
         sel1_q   <= sel1_d;
         sel3_q   <= sel3_d;
         w_r_q    <= w_r_d;
         retire_q <= retire_d;
      end
   end

   assign operand1 = op1_q;
   assign operand2 = op2_q;
   assign offset   = off_q;
   assign opcode   = opc_q;
   assign sel1     = sel1_q;
   assign sel3     = sel3_q;
   assign w_r      = w_r_q;
   assign retire   = retire_q;

endmodule

// File: tb/tb_cu_multicycle.sv
// Directed bench for cu_multicycle: vector table plus stream and reset-abort sequences.
module tb_cu_multicycle;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [19:0] instr;
   logic [7:0]  result2;
   logic [7:0]  operand1, operand2, offset;
   logic [3:0]  opcode;
   logic        sel1, sel3, w_r, retire;

   int total = 0;
   int bad   = 0;

`ifdef CU_ZERO_REG_EN
   localparam logic [7:0] R0_AFTER = 8'h00;
`else
   localparam logic [7:0] R0_AFTER = 8'h7F;
`endif

   always #5 clk = ~clk;

   cu_multicycle #(.DATA_WIDTH(8), .NUM_REGS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr      (instr),
      .result2    (result2),
      .operand1   (operand1),
      .operand2   (operand2),
      .offset     (offset),
      .opcode     (opcode),
      .sel1       (sel1),
      .sel3       (sel3),
      .w_r        (w_r),
      .retire     (retire)
   );

   typedef struct {
      logic [1:0] t;
      logic [1:0] rd, rs1, rs2;
      logic [7:0] off;
      logic [3:0] opc;
      logic [7:0] res;
      logic [7:0] e_op1, e_op2;
      logic       e_sel1, e_sel3;
      int         ret_cyc, wr_cyc, rdy_cyc;
   } vec_t;

   vec_t tbl [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [19:0] mk(input logic [1:0] t, input logic [1:0] rd, input logic [1:0] rs1,
                                      input logic [1:0] rs2, input logic [7:0] off, input logic [3:0] opc);
      return {t, rd, rs1, rs2, off, opc};
   endfunction

   // Offer one instruction, then walk its cycles checking retire / w_r / instr_ready.
   task automatic run_vec(input int idx, input vec_t v);
      @(negedge clk);
      instr       = mk(v.t, v.rd, v.rs1, v.rs2, v.off, v.opc);
      result2     = v.res;
      instr_valid = 1'b1;
      chk($sformatf("v%0d ready_before", idx), instr_ready, 1'b1);
      @(negedge clk);
      instr_valid = 1'b0;
      chk($sformatf("v%0d operand1", idx), operand1, v.e_op1);
      chk($sformatf("v%0d operand2", idx), operand2, v.e_op2);
      chk($sformatf("v%0d offset", idx), offset, v.off);
      chk($sformatf("v%0d opcode", idx), opcode, v.opc);
      chk($sformatf("v%0d sel1", idx), sel1, v.e_sel1);
      chk($sformatf("v%0d sel3", idx), sel3, v.e_sel3);
      for (int n = 1; n <= v.rdy_cyc; n++) begin
         if (n > 1) @(negedge clk);
         chk($sformatf("v%0d retire@k+%0d", idx, n), retire, (n == v.ret_cyc));
         chk($sformatf("v%0d w_r@k+%0d", idx, n), w_r, (n == v.wr_cyc));
         chk($sformatf("v%0d ready@k+%0d", idx, n), instr_ready, (n >= v.rdy_cyc));
      end
   endtask

   initial begin
      logic [19:0] stream [3];
      int acc [3];
      int idx, cyc, nret, nrdy;
      bit done;

      //         t      rd     rs1    rs2    off    opc   res    op1    op2    s1 s3 ret wr rdy
      tbl[0] = '{2'b01, 2'd3, 2'd1, 2'd2, 8'h00, 4'd2, 8'hAA, 8'h01, 8'h02, 1, 0, 3, 0, 4};
      tbl[1] = '{2'b10, 2'd1, 2'd2, 2'd0, 8'h10, 4'd0, 8'h5C, 8'h02, 8'h01, 0, 1, 4, 0, 5};
      tbl[2] = '{2'b01, 2'd2, 2'd3, 2'd1, 8'h00, 4'd7, 8'h11, 8'hAA, 8'h5C, 1, 0, 3, 0, 4};
      tbl[3] = '{2'b11, 2'd3, 2'd0, 2'd0, 8'h04, 4'd0, 8'hEE, 8'h00, 8'hAA, 0, 1, 3, 3, 4};
      tbl[4] = '{2'b00, 2'd2, 2'd2, 2'd1, 8'h99, 4'd9, 8'h77, 8'h11, 8'h11, 0, 1, 1, 0, 2};
      tbl[5] = '{2'b01, 2'd0, 2'd3, 2'd2, 8'h00, 4'd1, 8'h7F, 8'hAA, 8'h11, 1, 0, 3, 0, 4};
      tbl[6] = '{2'b01, 2'd1, 2'd0, 2'd1, 8'h00, 4'd3, 8'h20, R0_AFTER, 8'h5C, 1, 0, 3, 0, 4};

      rst         = 1'b1;
      instr_valid = 1'b0;
      instr       = '0;
      result2     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rst operand1", operand1, 8'h00);
      chk("rst operand2", operand2, 8'h00);
      chk("rst offset", offset, 8'h00);
      chk("rst opcode", opcode, 4'hF);
      chk("rst sel1", sel1, 1'b0);
      chk("rst sel3", sel3, 1'b0);
      chk("rst w_r", w_r, 1'b0);
      chk("rst retire", retire, 1'b0);
      chk("rst ready", instr_ready, 1'b1);

      for (int i = 0; i < 7; i++) run_vec(i, tbl[i]);

      // Valid held high over NOP, STD, NOP: accepts expected 2 and then 4 cycles apart.
      stream[0] = mk(2'b00, 2'd0, 2'd0, 2'd0, 8'h00, 4'd0);
      stream[1] = mk(2'b01, 2'd2, 2'd1, 2'd0, 8'h00, 4'd4);
      stream[2] = mk(2'b00, 2'd1, 2'd1, 2'd1, 8'h00, 4'd0);
      result2 = 8'h44;
      idx  = 0;
      cyc  = 0;
      nret = 0;
      nrdy = 0;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         cyc++;
         if (retire) nret++;
         if (instr_ready) begin
            nrdy++;
            if (idx < 3) begin
               instr       = stream[idx];
               instr_valid = 1'b1;
               acc[idx]    = cyc;
               idx++;
            end else begin
               instr_valid = 1'b0;
               done        = 1'b1;
            end
         end
      end
      instr_valid = 1'b0;
      chk("stream finished", done, 1'b1);
      chk("stream gap nop->std", acc[1] - acc[0], 2);
      chk("stream gap std->nop", acc[2] - acc[1], 4);
      chk("stream retires", nret, 3);
      chk("stream ready cycles", nrdy, 4);

      // Reset during EXECUTE of STD rd=3 must abort the write-back.
      @(negedge clk);
      instr       = mk(2'b01, 2'd3, 2'd0, 2'd0, 8'h21, 4'd6);
      result2     = 8'hFF;
      instr_valid = 1'b1;
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort operand1", operand1, 8'h00);
      chk("abort operand2", operand2, 8'h00);
      chk("abort offset", offset, 8'h00);
      chk("abort opcode", opcode, 4'hF);
      chk("abort sel1", sel1, 1'b0);
      chk("abort retire", retire, 1'b0);
      chk("abort w_r", w_r, 1'b0);
      chk("abort ready", instr_ready, 1'b1);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk($sformatf("abort quiet retire %0d", n), retire, 1'b0);
      end
      run_vec(7, '{2'b01, 2'd0, 2'd3, 2'd1, 8'h00, 4'd2, 8'h00, 8'h03, 8'h01, 1, 0, 3, 0, 4});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached before summary");
      $fatal(1, "timeout");
   end

endmodule
